// File: rtl/maze_draw_pkg.sv
// Shared types and constants for the maze renderer.
// Holds FSM encoding, screen limits and the palette.
package maze_draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_DONE,
    S_WAIT_RELEASE
  } state_e;

  typedef enum logic {
    OP_DRAW,
    OP_ERASE
  } op_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GRID_W   = 5;

  localparam logic [2:0] COL_BOX  = 3'b100;
  localparam logic [2:0] COL_PATH = 3'b111;
  localparam logic [2:0] COL_WALL = 3'b000;

endpackage

// File: rtl/cell_draw_engine_if.sv
// Draw/erase handshake from game logic plus the VGA plot port.
// The master is the position controller; the slave is the engine.
interface cell_draw_engine_if;
  import maze_draw_pkg::*;

  logic              drawBox;
  logic              eraseBox;
  logic [GRID_W-1:0] newX;
  logic [GRID_W-1:0] newY;
  logic [GRID_W-1:0] prevX;
  logic [GRID_W-1:0] prevY;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;
  logic              doneDraw;
  logic              doneErase;
  logic              busy;

  modport master (
    output drawBox, eraseBox,
    output newX, newY, prevX, prevY,
    input  vga_x, vga_y, vga_colour, vga_plot,
    input  doneDraw, doneErase, busy
  );

  modport slave (
    input  drawBox, eraseBox,
    input  newX, newY, prevX, prevY,
    output vga_x, vga_y, vga_colour, vga_plot,
    output doneDraw, doneErase, busy
  );

endinterface

// File: rtl/cell_pixel_scanner.sv
// Walks px/py across one cell and forms the screen address.
// start_i forces pixel (0,0) so the first plot needs no setup cycle.
module cell_pixel_scanner
  import maze_draw_pkg::*;
#(
  parameter int CELL_SIZE = 4,
  parameter int X_OFFSET  = 8,
  parameter int Y_OFFSET  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              adv_i,
  input  logic [GRID_W-1:0] cx_i,
  input  logic [GRID_W-1:0] cy_i,
  output logic [7:0]        x_o,
  output logic [6:0]        y_o,
  output logic              in_bounds_o,
  output logic              last_o
);

  localparam int CW = $clog2(CELL_SIZE);
  localparam logic [CW-1:0] PMAX = CW'(CELL_SIZE - 1);

  logic [CW-1:0] px_q, px_d, px_c;
  logic [CW-1:0] py_q, py_d, py_c;
  logic [8:0]    x9, y9;

  always_comb begin
    px_c = start_i ? '0 : px_q;
    py_c = start_i ? '0 : py_q;
    x9 = 9'(X_OFFSET) + (9'(cx_i) << CW) + 9'(px_c);
    y9 = 9'(Y_OFFSET) + (9'(cy_i) << CW) + 9'(py_c);
    in_bounds_o = (x9 < 9'(SCREEN_W)) && (y9 < 9'(SCREEN_H));
    last_o = (px_c == PMAX) && (py_c == PMAX);
    x_o = x9[7:0];
    y_o = y9[6:0];
    px_d = px_q;
    py_d = py_q;
    if (start_i || adv_i) begin
      if (px_c == PMAX) begin
        px_d = '0;
        py_d = py_c + 1'b1;
      end else begin
        px_d = px_c + 1'b1;
        py_d = py_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

endmodule

// File: rtl/cell_draw_engine.sv
// Rasterises one maze cell per draw/erase request onto the VGA port.
// Erase wins arbitration; WAIT_RELEASE stops a held level retriggering.
module cell_draw_engine
  import maze_draw_pkg::*;
#(
  parameter int         CELL_SIZE   = 4,
  parameter int         X_OFFSET    = 8,
  parameter int         Y_OFFSET    = 4,
  parameter logic [2:0] BOX_COLOUR  = COL_BOX,
  parameter logic [2:0] PATH_COLOUR = COL_PATH
) (
  input logic               clock,
  input logic               reset,
  cell_draw_engine_if.slave eng
);

  state_e            state_q;
  op_e               op_q;
  logic [GRID_W-1:0] cx_q, cy_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        col_q;
  logic              plot_q, dd_q, de_q;

  logic              idle, req, start, served;
  op_e               sel_op;
  logic [2:0]        sel_col;
  logic [GRID_W-1:0] sel_x, sel_y, scan_x, scan_y;
  logic [7:0]        sx;
  logic [6:0]        sy;
  logic              inb, last;

  always_comb begin
    idle    = (state_q == S_IDLE);
    req     = eng.eraseBox | eng.drawBox;
    sel_op  = eng.eraseBox ? OP_ERASE : OP_DRAW;
    sel_col = eng.eraseBox ? PATH_COLOUR : BOX_COLOUR;
    sel_x   = eng.eraseBox ? eng.prevX : eng.newX;
    sel_y   = eng.eraseBox ? eng.prevY : eng.newY;
    scan_x  = idle ? sel_x : cx_q;
    scan_y  = idle ? sel_y : cy_q;
    start   = idle && req;
    served  = (op_q == OP_ERASE) ? eng.eraseBox : eng.drawBox;
  end

  cell_pixel_scanner #(
    .CELL_SIZE (CELL_SIZE),
    .X_OFFSET  (X_OFFSET),
    .Y_OFFSET  (Y_OFFSET)
  ) u_scan (
    .clk_i       (clock),
    .rst_i       (reset),
    .start_i     (start),
    .adv_i       (state_q == S_PLOT),
    .cx_i        (scan_x),
    .cy_i        (scan_y),
    .x_o         (sx),
    .y_o         (sy),
    .in_bounds_o (inb),
    .last_o      (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_DRAW;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      dd_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      dd_q <= 1'b0;
      de_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q <= S_PLOT;
            op_q    <= sel_op;
            cx_q    <= sel_x;
            cy_q    <= sel_y;
            col_q   <= sel_col;
            x_q     <= sx;
            y_q     <= sy;
            plot_q  <= inb;
          end
        end
        S_PLOT: begin
          x_q    <= sx;
          y_q    <= sy;
          plot_q <= inb;
          if (last) state_q <= S_DONE;
        end
        // Last pixel is on the bus during DONE; strobe follows it.
        S_DONE: begin
          plot_q  <= 1'b0;
          de_q    <= (op_q == OP_ERASE);
          dd_q    <= (op_q == OP_DRAW);
          state_q <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!served) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng.vga_x      = x_q;
  assign eng.vga_y      = y_q;
  assign eng.vga_colour = col_q;
  assign eng.vga_plot   = plot_q;
  assign eng.doneDraw   = dd_q;
  assign eng.doneErase  = de_q;
  assign eng.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cell_draw_engine.sv
// Scoreboard bench for cell_draw_engine.
// Driver queues expected pixels/strobes; a negedge monitor checks them.
module tb_cell_draw_engine;

  localparam int CS = 4;
  localparam int XO = 8;
  localparam int YO = 4;
  localparam int NPIX = CS * CS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } pix_t;

  typedef struct {
    bit er;
    int cyc;
  } done_t;

  pix_t  pq[$];
  done_t dq[$];

  cell_draw_engine_if bus();

  cell_draw_engine #(
    .CELL_SIZE   (CS),
    .X_OFFSET    (XO),
    .Y_OFFSET    (YO),
    .BOX_COLOUR  (3'b100),
    .PATH_COLOUR (3'b111)
  ) dut (
    .clock (clk),
    .reset (rst),
    .eng   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pix_t  p;
    done_t d;
    if (mon_en) begin
      if (bus.vga_plot) begin
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_plot x=%0d y=%0d cyc=%0d",
                   bus.vga_x, bus.vga_y, cyc);
        end else begin
          p = pq.pop_front();
          if (int'(bus.vga_x) != p.x || int'(bus.vga_y) != p.y ||
              int'(bus.vga_colour) != p.c || cyc != p.cyc) begin
            failures++;
            $display("FAIL pixel got x=%0d y=%0d c=%0d cyc=%0d want x=%0d y=%0d c=%0d cyc=%0d",
                     bus.vga_x, bus.vga_y, bus.vga_colour, cyc,
                     p.x, p.y, p.c, p.cyc);
          end
        end
      end
      if (bus.doneDraw || bus.doneErase) begin
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done draw=%0b erase=%0b cyc=%0d",
                   bus.doneDraw, bus.doneErase, cyc);
        end else begin
          d = dq.pop_front();
          if (bus.doneErase !== d.er || bus.doneDraw !== !d.er ||
              cyc != d.cyc) begin
            failures++;
            $display("FAIL done got draw=%0b erase=%0b cyc=%0d want erase=%0b cyc=%0d",
                     bus.doneDraw, bus.doneErase, cyc, d.er, d.cyc);
          end
        end
      end
    end
  end

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, got, exp);
    end
  endtask

  task automatic push_cell(int cx, int cy, int col, int s);
    for (int j = 0; j < CS; j++) begin
      for (int i = 0; i < CS; i++) begin
        int xx;
        int yy;
        xx = XO + cx * CS + i;
        yy = YO + cy * CS + j;
        if (xx < 160 && yy < 120)
          pq.push_back('{x: xx, y: yy, c: col, cyc: s + j * CS + i});
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle timeout busy=1 want=0");
  endtask

  task automatic wait_done(bit er);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (er ? bus.doneErase : bus.doneDraw) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_done timeout erase=%0b got=0 want=1", er);
  endtask

  task automatic do_req(bit dr, bit er, int nx, int ny,
                        int qx, int qy, int hold);
    int s;
    int sd;
    wait_idle();
    bus.newX     = 5'(nx);
    bus.newY     = 5'(ny);
    bus.prevX    = 5'(qx);
    bus.prevY    = 5'(qy);
    bus.drawBox  = dr;
    bus.eraseBox = er;
    s = cyc + 1;
    if (er) begin
      push_cell(qx, qy, 7, s);
      dq.push_back('{er: 1'b1, cyc: s + NPIX});
    end
    if (dr) begin
      sd = er ? s + NPIX + 2 + hold : s;
      push_cell(nx, ny, 4, sd);
      dq.push_back('{er: 1'b0, cyc: sd + NPIX});
    end
    @(negedge clk);
    @(negedge clk);
    if (er) begin
      bus.prevX = 5'($urandom);
      bus.prevY = 5'($urandom);
    end else begin
      bus.newX = 5'($urandom);
      bus.newY = 5'($urandom);
    end
    if (er) begin
      wait_done(1'b1);
      repeat (hold) @(negedge clk);
      bus.eraseBox = 1'b0;
    end
    if (dr) begin
      wait_done(1'b0);
      repeat (hold) @(negedge clk);
      if (hold > 0) chk("busy_while_held", int'(bus.busy), 1);
      bus.drawBox = 1'b0;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_vga_x"}, int'(bus.vga_x), 0);
    chk({tag, "_vga_y"}, int'(bus.vga_y), 0);
    chk({tag, "_colour"}, int'(bus.vga_colour), 0);
    chk({tag, "_plot"}, int'(bus.vga_plot), 0);
    chk({tag, "_doneDraw"}, int'(bus.doneDraw), 0);
    chk({tag, "_doneErase"}, int'(bus.doneErase), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int s;
    int m;
    bus.drawBox  = 1'b0;
    bus.eraseBox = 1'b0;
    bus.newX     = '0;
    bus.newY     = '0;
    bus.prevX    = '0;
    bus.prevY    = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    do_req(1, 0, 1, 0, 0, 0, 0);
    do_req(0, 1, 0, 0, 2, 3, 0);
    do_req(1, 1, 4, 5, 6, 7, 0);
    do_req(1, 0, 7, 2, 0, 0, 5);
    do_req(1, 0, 31, 31, 0, 0, 0);

    wait_idle();
    bus.newX = 5'd3;
    bus.newY = 5'd2;
    bus.drawBox = 1'b1;
    s = cyc + 1;
    push_cell(3, 2, 4, s);
    for (int k = 0; k < 40 && cyc < s + 7; k++) @(negedge clk);
    #1;
    rst = 1'b1;
    bus.drawBox = 1'b0;
    pq.delete();
    dq.delete();
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_req(1, 0, 5, 5, 0, 0, 0);

    for (int n = 0; n < 12; n++) begin
      m = $urandom_range(0, 2);
      do_req(m != 1, m != 0,
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 3));
    end

    repeat (40) @(negedge clk);
    chk("pixels_left", pq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_draw_engine.md
Name: cell_draw_engine

Overview:
- Responder side of the player-marker draw/erase handshake issued by the game position controller.
- Accepts a draw or erase request for one maze cell in 5-bit grid coordinates and rasterises that cell as a CELL_SIZE x CELL_SIZE square of VGA pixel writes, one pixel per clock.
- Pulses the matching done strobe when the square is complete.
- Sits between the game-logic handshake outputs and the VGA adapter's plot port.

Parameters:
- CELL_SIZE, 4, pixels per cell edge (power of two, 2..8).
- X_OFFSET, 8, screen x of grid cell column 0.
- Y_OFFSET, 4, screen y of grid cell row 0.
- BOX_COLOUR, 3'b100, colour written on draw (player marker).
- PATH_COLOUR, 3'b111, colour written on erase (empty path).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- drawBox  in  1  draw request, level, held by initiator until doneDraw
- eraseBox  in  1  erase request, level, held until doneErase
- newX  in  5  grid column for draw
- newY  in  5  grid row for draw
- prevX  in  5  grid column for erase
- prevY  in  5  grid row for erase
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable
- doneDraw  out  1  one-cycle pulse, draw complete
- doneErase  out  1  one-cycle pulse, erase complete
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, doneDraw=0, doneErase=0, busy=0. Reset wins over every other event, including mid-square; no done pulse is produced for an aborted request.
- States: IDLE, PLOT, DONE, WAIT_RELEASE.
- IDLE:
  - Samples requests each cycle; if eraseBox=1, latches prevX/prevY, selects PATH_COLOUR, op=ERASE.
  - Else if drawBox=1, latches newX/newY, selects BOX_COLOUR, op=DRAW.
  - Pixel counters px=py=0. Any request -> PLOT.
- Simultaneous drawBox and eraseBox: erase served first. Draw is served on the next IDLE entry (still held).
- PLOT:
  - One pixel per cycle, registered outputs.
  - vga_x = X_OFFSET + cx*CELL_SIZE + px; vga_y = Y_OFFSET + cy*CELL_SIZE + py.
  - Computed at 9 bits. vga_plot=1 only if x<=159 and y<=119; otherwise vga_plot=0 and vga_x/vga_y hold truncated values, but the scan still advances.
  - px increments each cycle and wraps at CELL_SIZE-1, incrementing py. After px=py=CELL_SIZE-1 -> DONE.
- DONE (one cycle): vga_plot=0; doneErase=1 if op=ERASE, else doneDraw=1 -> WAIT_RELEASE.
- WAIT_RELEASE: stay until the served request input is 0, then -> IDLE. The other request is ignored here, which prevents a held level from retriggering.
- Latency: request high in IDLE at cycle t -> first vga_plot at t+1 -> last pixel at t+CELL_SIZE^2 -> done pulse at t+CELL_SIZE^2+1.
- Coordinate inputs are sampled only in IDLE; changes during PLOT are ignored.
- Requests arriving while busy are not lost if held; they are sampled on the next IDLE.

Decomposition:
- Shared package (maze_draw_pkg):
  - state encoding
  - screen limits 160x120
  - colour constants: BOX, PATH, WALL
  - grid coordinate width 5
- One natural sub-module, cell_pixel_scanner:
  - px/py counters
  - start input, last-pixel flag
  - offset/scale address arithmetic and in-bounds flag
- Top: FSM, request arbitration, latches, done strobes.

Test Plan:
- Reset, then drawBox=1, newX=1, newY=0 (defaults) -> 16 plots (x 12..15, y 4..7, colour 3'b100) at cycles t+1..t+16; doneDraw pulses at t+17 for exactly one cycle.
- eraseBox=1, prevX=2, prevY=3 -> 16 plots (x 16..19, y 16..19, colour 3'b111); doneErase at t+17; doneDraw stays 0.
- drawBox and eraseBox both high, held until their own done -> erase square, doneErase, then draw square, doneDraw; no overlap, no pixels between.
- drawBox held 5 cycles past doneDraw -> engine in WAIT_RELEASE, no second square; next rising request is served normally.
- newX=31, newY=31 (x=132..135, y=128..131) -> vga_plot stays 0 for all 16 cycles; doneDraw still at t+17.
- reset asserted at pixel 7 of a draw -> next cycle all outputs 0, state IDLE, no done pulse; a fresh request afterwards completes normally.
